sub16_serial: RTL and testbench
===============================

Name: sub16_serial

Overview:
- Bit-serial 16-bit subtractor/decrementer; the inverse operation of the ALU's ripple adder and incrementer.
- Processes one bit per clock, LSB first, using a single borrow flip-flop.
- Sits beside the combinational arithmetic as a low-area datapath unit driven by the controller through a start/done handshake.
- Produces the difference plus borrow, zero, negative and signed-overflow flags.

Parameters:
- WIDTH, 16, operand and result width in bits. The bit counter is sized to hold WIDTH-1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request pulse; sampled only when not busy.
- op  input  1  0 = a - b; 1 = a - 1 (decrement, b ignored).
- a  input  WIDTH  minuend, latched on an accepted start.
- b  input  WIDTH  subtrahend, latched on an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- diff  output  WIDTH  result a - b (mod 2^WIDTH).
- borrow  output  1  1 when unsigned a < b.
- zero  output  1  1 when diff == 0.
- neg  output  1  equals diff[WIDTH-1].
- ovf  output  1  signed overflow.

Behaviour:
- Reset: when rst_n is low at a rising edge, state=IDLE and busy=0, done=0, diff=0, borrow=0, zero=0, neg=0, ovf=0. The operand registers, bit counter and borrow flip-flop are also cleared.
- Reset has priority over everything. Asserting it mid-RUN aborts the operation, and no done pulse is produced.
- State machine IDLE, RUN, DONE:
  - IDLE: if start=1 at an edge, latch a into A_r. Latch B_r = (op ? 1 : b). Set cnt=0, borrow_ff=0, clear the diff shift register, go to RUN. busy becomes 1 after that edge.
  - RUN, each edge, bit i=cnt:
    - d = A_r[i] ^ B_r[i] ^ borrow_ff
    - borrow_ff <= (~A_r[i] & B_r[i]) | (~(A_r[i] ^ B_r[i]) & borrow_ff)
    - diff[i] <= d; cnt <= cnt+1
  - RUN exit: on the edge processing i=WIDTH-1, go to DONE and register the flags from the final values.
    - borrow = final borrow_ff
    - zero = (complete diff == 0)
    - neg = diff[WIDTH-1]
    - ovf = (A_r[MSB] != B_r[MSB]) & (diff[MSB] != A_r[MSB])
  - DONE: lasts exactly one cycle with done=1, busy=0. The next edge returns to IDLE.
    - If start=1 at that edge, it is accepted directly (DONE -> RUN) as if from IDLE.
- Latency: start accepted at edge E0. Bits are processed at edges E1..E16 (WIDTH edges). done=1 and the result is valid in the cycle after E16. The next start can be accepted at E17.
- busy is high from after E0 through after E15 (i.e. during RUN), and low in DONE/IDLE.
- start while busy=1 is ignored entirely: no operand relatch and no queuing.
- diff and the flags are updated only by a completed operation; they hold until the next completion or reset.
  - diff is not externally stable during RUN. During RUN the output ports show the previous result, because a separate shift register is copied to diff on completion.
- Wrap-around: the result is modulo 2^WIDTH. 0 - 1 gives all ones with borrow=1.
- op is sampled only at acceptance. Changes to op, a or b during RUN have no effect.

Test Plan:
- Basic: reset, then start with op=0, a=5, b=3 -> busy for 16 cycles, done pulse once; diff=0x0002, borrow=0, zero=0, neg=0, ovf=0.
- Underflow: a=3, b=5 -> diff=0xFFFE, borrow=1, neg=1, ovf=0.
- Signed overflow and decrement: op=1, a=0x8000 -> diff=0x7FFF, ovf=1, borrow=0. Then op=1, a=0x0000 -> diff=0xFFFF, borrow=1, neg=1.
- Zero and handshake:
  - a=b=0x1234 -> diff=0, zero=1.
  - Pulse start again at cycle 5 of RUN with a=9 -> ignored; the result is still 0.
  - A start asserted in the DONE cycle is accepted, with the next done exactly 17 cycles after the first.
- Reset mid-op: start a=7, b=2, drop rst_n at RUN cycle 8 -> all outputs 0, no done pulse. After release, a new start 7-2 -> diff=5.
- Random: 1000 random a/b/op vectors compared against a reference model -> diff and all flags match, done exactly once per accepted start.

Source files
------------

// File: rtl/sub16_serial.sv
// sub16_serial: bit-serial subtractor/decrementer, LSB first.
// One borrow flop; difference and flags are published on completion.
module sub16_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] full;
    logic [CW-1:0]    cnt;
    logic             bff;
    logic             ai;
    logic             bi;
    logic             d;
    logic             bnx;
    logic             last;
    logic             accept;

    // Current bit slice: difference bit, next borrow, completed word.
    always_comb begin
        ai        = a_r[cnt];
        bi        = b_r[cnt];
        d         = ai ^ bi ^ bff;
        bnx       = (~ai & bi) | (~(ai ^ bi) & bff);
        last      = (cnt == LAST);
        full      = sr;
        full[cnt] = d;
    end

    // A start is taken in IDLE or straight out of DONE, never in RUN.
    assign accept = start && (state != RUN);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = start ? RUN : IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand latch, serial datapath and result/flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            sr     <= '0;
            cnt    <= '0;
            bff    <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_r <= a;
            b_r <= op ? WIDTH'(1) : b;
            sr  <= '0;
            cnt <= '0;
            bff <= 1'b0;
        end else if (state == RUN) begin
            sr[cnt] <= d;
            bff     <= bnx;
            cnt     <= cnt + CW'(1);
            if (last) begin
                diff   <= full;
                borrow <= bnx;
                zero   <= (full == '0);
                neg    <= full[MSB];
                ovf    <= (a_r[MSB] ^ b_r[MSB])
                        & (full[MSB] ^ a_r[MSB]);
            end
        end
    end

endmodule

// File: tb/tb_sub16_serial.sv
// tb_sub16_serial: directed + random checks for sub16_serial.
// Expected results are queued at start and compared on done.
module tb_sub16_serial;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
    logic         neg;
    logic         ovf;

    typedef struct {
        logic [W-1:0] d;
        logic         br;
        logic         z;
        logic         n;
        logic         v;
    } exp_t;

    exp_t         sb[$];
    int           errors = 0;
    int           checks = 0;
    int           accepts = 0;
    int           dones = 0;
    logic [W-1:0] last_diff = '0;

    sub16_serial #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .zero   (zero),
        .neg    (neg),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic o,
                                   input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        exp_t e;
        logic [W-1:0] bb;
        bb   = o ? W'(1) : y;
        e.d  = x - bb;
        e.br = (x < bb);
        e.z  = (e.d == '0);
        e.n  = e.d[W-1];
        e.v  = (x[W-1] != bb[W-1]) && (e.d[W-1] != x[W-1]);
        return e;
    endfunction

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            exp_t e;
            dones++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(1'b0));
            end else begin
                e = sb.pop_front();
                chk("diff", 32'(diff), 32'(e.d));
                chk("borrow", 32'(borrow), 32'(e.br));
                chk("zero", 32'(zero), 32'(e.z));
                chk("neg", 32'(neg), 32'(e.n));
                chk("ovf", 32'(ovf), 32'(e.v));
                last_diff = e.d;
            end
        end
    end

    task automatic push(input logic o,
                        input logic [W-1:0] x,
                        input logic [W-1:0] y);
        sb.push_back(model(o, x, y));
        accepts++;
    endtask

    // Wait for done; n counts negedges since the start edge.
    task automatic wait_done(inout int n);
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done), 32'(1'b1));
    endtask

    task automatic run_op(input logic o,
                          input logic [W-1:0] x,
                          input logic [W-1:0] y);
        int n;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        push(o, x, y);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = $urandom_range(0, 1);
        n     = 1;
        chk("busy_after_start", 32'(busy), 32'(1'b1));
        repeat (7) begin
            @(negedge clk);
            n++;
        end
        chk("diff_held_in_run", 32'(diff), 32'(last_diff));
        wait_done(n);
        chk("latency", 32'(n), 32'd17);
        chk("busy_in_done", 32'(busy), 32'(1'b0));
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(1'b0));
        chk("rst_done", 32'(done), 32'(1'b0));
        chk("rst_diff", 32'(diff), 32'(0));
        chk("rst_flags", 32'({borrow, zero, neg, ovf}), 32'(0));
        rst_n = 1'b1;

        run_op(1'b0, 16'd5, 16'd3);
        run_op(1'b0, 16'd3, 16'd5);
        run_op(1'b1, 16'h8000, 16'h1234);
        run_op(1'b1, 16'h0000, 16'h0000);

        // Equal operands, then a start pulse in RUN that must be ignored.
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        a     = 16'h1234;
        b     = 16'h1234;
        push(1'b0, 16'h1234, 16'h1234);
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        repeat (4) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        a     = 16'd9;
        b     = 16'd0;
        @(negedge clk);
        n++;
        start = 1'b0;
        wait_done(n);
        chk("latency_ignored", 32'(n), 32'd17);

        // Start in the DONE cycle is accepted directly.
        start = 1'b1;
        op    = 1'b0;
        a     = 16'h00F0;
        b     = 16'h000F;
        push(1'b0, 16'h00F0, 16'h000F);
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        wait_done(n);
        chk("done_to_done", 32'(n), 32'd17);

        // Reset in the middle of RUN aborts with no done.
        @(negedge clk);
        start = 1'b1;
        a     = 16'd7;
        b     = 16'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy", 32'(busy), 32'(1'b0));
        chk("abort_done", 32'(done), 32'(1'b0));
        chk("abort_diff", 32'(diff), 32'(0));
        chk("abort_flags", 32'({borrow, zero, neg, ovf}), 32'(0));
        rst_n     = 1'b1;
        last_diff = '0;
        repeat (20) @(negedge clk);
        chk("abort_no_done", 32'(dones), 32'(accepts));
        run_op(1'b0, 16'd7, 16'd2);

        // Random vectors against the reference model.
        for (int i = 0; i < 1000; i++) begin
            run_op(1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(sb.size()), 32'd0);
        chk("done_count", 32'(dones), 32'(accepts));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
